print_log_buffer: RTL and testbench

- Downstream consumer of the core's print-store decode (the byte written to the PRINT address on the data bus).
- Buffers each printed byte in a small FIFO and drains it, one byte per transfer, into an on-chip log memory through an Avalon-MM style write port with waitrequest.
- Keeps an incrementing log address, stops at a fixed log capacity, and counts bytes it could not store.
- Lets a stalled or slow log memory absorb bursts without ever back-pressuring the core.

---
 rtl/print_log_buffer.sv | 86 ++++++++
 tb/tb_print_log_buffer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/print_log_buffer.sv
// print_log_buffer: buffers print-store bytes in a FIFO and drains them into a log memory write port
// Ports: clk_i/rst_i clock and synchronous active-high reset; req_i/wdata_i print strobe and byte;
//        clear_i restarts the log; mem_req_o/mem_addr_o/mem_wdata_o/mem_wait_i log memory write port
//        with waitrequest; full_o FIFO full; done_o log capacity reached; count_o bytes committed;
//        drop_cnt_o saturating count of discarded bytes
module print_log_buffer #(
  parameter int DEPTH       = 8,
  parameter int LOG_ENTRIES = 800,
  parameter int ADDR_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic [7:0]        wdata_i,
  input  logic              clear_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic              mem_wait_i,
  output logic              full_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] count_o,
  output logic [15:0]       drop_cnt_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0, S_WRITE = 2'd1, S_DONE = 2'd2;
  localparam logic [ADDR_W-1:0] LOG_MAX = ADDR_W'(LOG_ENTRIES);
  localparam logic [PW:0] OCC_FULL = (PW+1)'(DEPTH);
  logic [7:0]        r_fifo [DEPTH];
  logic [PW-1:0]     r_wr, r_rd;
  logic [PW:0]       r_occ;
  logic [1:0]        r_state;
  logic              r_clr_pend;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr, r_count;
  logic [7:0]        r_mem_wdata;
  logic [15:0]       r_drop;
  logic              w_full, w_empty, w_in_done, w_cmpl, w_clr, w_push, w_drop, w_start, w_to_done, w_flush;
  logic [ADDR_W-1:0] w_cnt_inc;
  assign w_full    = r_occ == OCC_FULL;
  assign w_empty   = r_occ == '0;
  assign w_in_done = r_state == S_DONE;
  assign w_cmpl    = r_state == S_WRITE && !mem_wait_i;
  // a clear seen during WRITE waits for the transfer to complete so the in-flight byte still lands
  assign w_clr     = (clear_i && r_state != S_WRITE) || (w_cmpl && (r_clr_pend || clear_i));
  assign w_push    = req_i && !w_full && !w_in_done && !w_clr;
  assign w_drop    = req_i && (w_full || w_in_done) && !w_clr;
  assign w_cnt_inc = r_count + 1'b1;
  assign w_start   = r_state == S_IDLE && !w_clr && !w_empty && r_count < LOG_MAX;
  assign w_to_done = !w_clr && ((w_cmpl && w_cnt_inc == LOG_MAX) || (r_state == S_IDLE && r_count == LOG_MAX));
  // entering DONE discards whatever is still queued, including a push on that same edge
  assign w_flush   = w_clr || w_to_done;
  always_ff @(posedge clk_i) if (w_push) r_fifo[r_wr] <= wdata_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr        <= '0;
      r_rd        <= '0;
      r_occ       <= '0;
      r_state     <= S_IDLE;
      r_clr_pend  <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_count     <= '0;
      r_drop      <= '0;
    end else begin
      r_wr        <= w_flush ? '0 : r_wr + PW'(w_push);
      r_rd        <= w_flush ? '0 : r_rd + PW'(w_cmpl);
      r_occ       <= w_flush ? '0 : r_occ + (PW+1)'(w_push) - (PW+1)'(w_cmpl);
      r_state     <= w_clr ? S_IDLE : w_to_done ? S_DONE : w_start ? S_WRITE : w_cmpl ? S_IDLE : r_state;
      r_clr_pend  <= r_state == S_WRITE && !w_cmpl && (r_clr_pend || clear_i);
      r_mem_req   <= w_start || (r_mem_req && !w_cmpl);
      r_mem_addr  <= w_start ? r_count : w_cmpl ? '0 : r_mem_addr;
      r_mem_wdata <= w_start ? r_fifo[r_rd] : w_cmpl ? '0 : r_mem_wdata;
      r_count     <= w_clr ? '0 : w_cmpl ? w_cnt_inc : r_count;
      r_drop      <= w_clr ? '0 : (w_drop && r_drop != 16'hFFFF) ? r_drop + 1'b1 : r_drop;
    end
  end
  assign mem_req_o   = r_mem_req;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign full_o      = w_full;
  assign done_o      = w_in_done;
  assign count_o     = r_count;
  assign drop_cnt_o  = r_drop;
endmodule

// File: tb/tb_print_log_buffer.sv
// tb_print_log_buffer: checks print_log_buffer (default capacity and a 4-byte log) against a queue-level model
module tb_print_log_buffer;
  localparam int DEPTH = 8;
  logic clk = 1'b0, rst_i = 1'b0, req_i = 1'b0, clear_i = 1'b0, mem_wait_i = 1'b0;
  logic [7:0] wdata_i = '0;
  logic        o_req [2];
  logic [31:0] o_addr [2];
  logic [7:0]  o_wd [2];
  logic        o_full [2];
  logic        o_done [2];
  logic [31:0] o_cnt [2];
  logic [15:0] o_drop [2];
  int n_cmp = 0, n_bad = 0;
  // reference model: mode 0 idle, 1 writing, 2 done; queue held as a shifting array
  int          ms [2];
  int          mn [2];
  logic [7:0]  mf [2][DEPTH];
  logic        mp [2], mr [2];
  logic [31:0] ma [2], mc [2];
  logic [7:0]  mw [2];
  logic [15:0] md [2];
  logic [31:0] xa0[$], xa1[$];
  logic [7:0]  xd0[$], xd1[$];
  int hi0 = 0;
  always #5 clk = ~clk;
  print_log_buffer #(.DEPTH(DEPTH), .LOG_ENTRIES(800), .ADDR_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .wdata_i(wdata_i), .clear_i(clear_i),
    .mem_req_o(o_req[0]), .mem_addr_o(o_addr[0]), .mem_wdata_o(o_wd[0]), .mem_wait_i(mem_wait_i),
    .full_o(o_full[0]), .done_o(o_done[0]), .count_o(o_cnt[0]), .drop_cnt_o(o_drop[0]));
  print_log_buffer #(.DEPTH(DEPTH), .LOG_ENTRIES(4), .ADDR_W(32)) dut4 (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .wdata_i(wdata_i), .clear_i(clear_i),
    .mem_req_o(o_req[1]), .mem_addr_o(o_addr[1]), .mem_wdata_o(o_wd[1]), .mem_wait_i(mem_wait_i),
    .full_o(o_full[1]), .done_o(o_done[1]), .count_o(o_cnt[1]), .drop_cnt_o(o_drop[1]));
  task automatic model_update(input logic r, input logic [7:0] d, input logic c, input logic w, input logic rs);
    for (int k = 0; k < 2; k++) begin
      int lim;
      logic wr, dn, cm, cl, fl, acc, drp;
      lim = (k == 1) ? 4 : 800;
      wr = ms[k] == 1;
      dn = ms[k] == 2;
      cm = wr && !w;
      cl = (c && !wr) || (cm && (mp[k] || c));
      fl = mn[k] == DEPTH;
      acc = r && !cl && !fl && !dn;
      drp = r && !cl && (fl || dn);
      if (rs) begin
        ms[k] = 0; mn[k] = 0; mp[k] = 0; mr[k] = 0; ma[k] = 0; mc[k] = 0; mw[k] = 0; md[k] = 0;
      end else begin
        if (drp && md[k] != 16'hFFFF) md[k] = md[k] + 1;
        mp[k] = wr && !cm && (mp[k] || c);
        if (cl) begin
          mn[k] = 0; mc[k] = 0; md[k] = 0; ms[k] = 0; mr[k] = 0; ma[k] = 0; mw[k] = 0;
        end else begin
          if (cm) begin
            for (int i = 0; i < DEPTH - 1; i++) mf[k][i] = mf[k][i+1];
            mn[k] = mn[k] - 1;
            mc[k] = mc[k] + 1;
            mr[k] = 0; ma[k] = 0; mw[k] = 0;
            ms[k] = (mc[k] == lim) ? 2 : 0;
            if (ms[k] == 2) mn[k] = 0;
          end else if (ms[k] == 0 && mc[k] == lim) begin
            ms[k] = 2; mn[k] = 0;
          end else if (ms[k] == 0 && mn[k] > 0) begin
            ms[k] = 1; mr[k] = 1; ma[k] = mc[k]; mw[k] = mf[k][0];
          end
          if (acc && ms[k] != 2) begin
            mf[k][mn[k]] = d;
            mn[k] = mn[k] + 1;
          end
        end
      end
    end
  endtask
  task automatic step(input logic r, input logic [7:0] d, input logic c, input logic w, input logic rs);
    req_i = r; wdata_i = d; clear_i = c; mem_wait_i = w; rst_i = rs;
    #1;
    if (!rs && o_req[0] && !w) begin xa0.push_back(o_addr[0]); xd0.push_back(o_wd[0]); end
    if (!rs && o_req[1] && !w) begin xa1.push_back(o_addr[1]); xd1.push_back(o_wd[1]); end
    if (o_req[0]) hi0++;
    model_update(r, d, c, w, rs);
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic clear_logs();
    xa0.delete(); xd0.delete(); xa1.delete(); xd1.delete(); hi0 = 0;
  endtask
  task automatic test_reset();
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({o_req[k], o_addr[k], o_wd[k], o_full[k], o_done[k], o_cnt[k], o_drop[k]} !== '0) begin
        n_bad++;
        $display("FAIL reset[%0d]: got req=%0b addr=%0h wd=%0h full=%0b done=%0b cnt=%0d drop=%0d, want all 0",
                 k, o_req[k], o_addr[k], o_wd[k], o_full[k], o_done[k], o_cnt[k], o_drop[k]);
      end
    end
  endtask
  task automatic test_abc();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h41; exp_d[1] = 8'h42; exp_d[2] = 8'h43;
    step(0, 8'h00, 0, 0, 1);
    clear_logs();
    for (int i = 0; i < 3; i++) step(1, exp_d[i], 0, 0, 0);
    repeat (10) step(0, 8'h00, 0, 0, 0);
    n_cmp++;
    if (xa0.size() != 3) begin n_bad++; $display("FAIL abc_nwrites: got %0d want 3", xa0.size()); end
    for (int i = 0; i < 3 && i < xa0.size(); i++) begin
      n_cmp++;
      if (xa0[i] !== 32'(i) || xd0[i] !== exp_d[i]) begin
        n_bad++;
        $display("FAIL abc_write%0d: got addr=%0d data=%0h want addr=%0d data=%0h", i, xa0[i], xd0[i], i, exp_d[i]);
      end
    end
    n_cmp++;
    if (hi0 != 3) begin n_bad++; $display("FAIL abc_pulse_width: got %0d req cycles want 3", hi0); end
    n_cmp++;
    if (o_cnt[0] !== 32'd3 || o_drop[0] !== 16'd0) begin
      n_bad++; $display("FAIL abc_counts: got cnt=%0d drop=%0d want cnt=3 drop=0", o_cnt[0], o_drop[0]);
    end
  endtask
  task automatic test_stall();
    step(0, 8'h00, 0, 0, 1);
    clear_logs();
    for (int i = 0; i < 10; i++) step(1, 8'h10 + 8'(i), 0, 1, 0);
    n_cmp++;
    if (o_full[0] !== 1'b1 || o_drop[0] !== 16'd2) begin
      n_bad++; $display("FAIL stall_full: got full=%0b drop=%0d want full=1 drop=2", o_full[0], o_drop[0]);
    end
    repeat (3) step(0, 8'h00, 0, 1, 0);
    n_cmp++;
    if (o_req[0] !== 1'b1 || o_addr[0] !== 32'd0 || o_wd[0] !== 8'h10) begin
      n_bad++; $display("FAIL stall_hold: got req=%0b addr=%0d wd=%0h want req=1 addr=0 wd=10", o_req[0], o_addr[0], o_wd[0]);
    end
    repeat (20) step(0, 8'h00, 0, 0, 0);
    n_cmp++;
    if (xa0.size() != 8) begin n_bad++; $display("FAIL stall_nwrites: got %0d want 8", xa0.size()); end
    for (int i = 0; i < 8 && i < xa0.size(); i++) begin
      n_cmp++;
      if (xa0[i] !== 32'(i) || xd0[i] !== 8'h10 + 8'(i)) begin
        n_bad++;
        $display("FAIL stall_write%0d: got addr=%0d data=%0h want addr=%0d data=%0h", i, xa0[i], xd0[i], i, 8'h10 + 8'(i));
      end
    end
  endtask
  task automatic test_done();
    step(0, 8'h00, 0, 0, 1);
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      step(1, 8'h60 + 8'(i), 0, 0, 0);
      step(0, 8'h00, 0, 0, 0);
      step(0, 8'h00, 0, 0, 0);
    end
    repeat (6) step(0, 8'h00, 0, 0, 0);
    n_cmp++;
    if (xa1.size() != 4) begin n_bad++; $display("FAIL done_nwrites: got %0d want 4", xa1.size()); end
    for (int i = 0; i < 4 && i < xa1.size(); i++) begin
      n_cmp++;
      if (xa1[i] !== 32'(i) || xd1[i] !== 8'h60 + 8'(i)) begin
        n_bad++;
        $display("FAIL done_write%0d: got addr=%0d data=%0h want addr=%0d data=%0h", i, xa1[i], xd1[i], i, 8'h60 + 8'(i));
      end
    end
    n_cmp++;
    if (o_done[1] !== 1'b1 || o_cnt[1] !== 32'd4 || o_drop[1] !== 16'd2 || o_req[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL done_state: got done=%0b cnt=%0d drop=%0d req=%0b want done=1 cnt=4 drop=2 req=0",
               o_done[1], o_cnt[1], o_drop[1], o_req[1]);
    end
  endtask
  task automatic test_clear_stall();
    step(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 8'h20 + 8'(i), 0, 0, 0);
    repeat (12) step(0, 8'h00, 0, 0, 0);
    clear_logs();
    step(1, 8'h77, 0, 1, 0);
    step(0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 1, 1, 0);
    step(0, 8'h00, 0, 1, 0);
    n_cmp++;
    if (o_req[0] !== 1'b1 || o_addr[0] !== 32'd5 || o_wd[0] !== 8'h77) begin
      n_bad++; $display("FAIL clear_hold: got req=%0b addr=%0d wd=%0h want req=1 addr=5 wd=77", o_req[0], o_addr[0], o_wd[0]);
    end
    step(0, 8'h00, 0, 0, 0);
    n_cmp++;
    if (xa0.size() != 1 || xa0[0] !== 32'd5 || xd0[0] !== 8'h77 || o_cnt[0] !== 32'd0) begin
      n_bad++; $display("FAIL clear_commit: got nwrites=%0d cnt=%0d want write of 77 at addr 5 then cnt=0", xa0.size(), o_cnt[0]);
    end
    clear_logs();
    step(1, 8'h88, 0, 0, 0);
    repeat (4) step(0, 8'h00, 0, 0, 0);
    n_cmp++;
    if (xa0.size() != 1 || xa0[0] !== 32'd0 || xd0[0] !== 8'h88) begin
      n_bad++; $display("FAIL clear_next: got nwrites=%0d want one write of 88 at addr 0", xa0.size());
    end
  endtask
  task automatic test_saturate();
    step(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 70000; i++) step(1, 8'(i), 0, 1, 0);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (o_drop[k] !== 16'hFFFF || o_req[k] !== 1'b1) begin
        n_bad++; $display("FAIL saturate[%0d]: got drop=%0h req=%0b want drop=ffff req=1", k, o_drop[k], o_req[k]);
      end
    end
  endtask
  task automatic test_reset_write();
    step(1, 8'h55, 0, 1, 1);
    step(0, 8'h00, 0, 1, 0);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({o_req[k], o_addr[k], o_wd[k], o_full[k], o_done[k], o_cnt[k], o_drop[k]} !== '0) begin
        n_bad++;
        $display("FAIL reset_write[%0d]: got req=%0b addr=%0h full=%0b cnt=%0d drop=%0d, want all 0",
                 k, o_req[k], o_addr[k], o_full[k], o_cnt[k], o_drop[k]);
      end
    end
  endtask
  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      step(1'($urandom_range(0, 9) < 6), 8'($urandom), 1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 299) == 0));
      for (int k = 0; k < 2; k++) begin
        logic [90:0] got, want;
        got  = {o_req[k], o_addr[k], o_wd[k], o_full[k], o_done[k], o_cnt[k], o_drop[k]};
        want = {mr[k], ma[k], mw[k], 1'(mn[k] == DEPTH), 1'(ms[k] == 2), mc[k], md[k]};
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL random[%0d] cycle %0d: got %h want %h", k, c, got, want);
        end
      end
    end
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      ms[k] = 0; mn[k] = 0; mp[k] = 0; mr[k] = 0; ma[k] = 0; mc[k] = 0; mw[k] = 0; md[k] = 0;
    end
    @(negedge clk);
    test_reset();
    test_abc();
    test_stall();
    test_done();
    test_clear_stall();
    test_saturate();
    test_reset_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
